hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between the ID, EX and MEM stages and driving the PC and pipeline-register write enables. It detects load-use hazards and inserts a configurable number of bubbles. It flushes IF/ID on taken branches and freezes the whole pipeline while data memory is not ready. A watchdog flags a memory timeout.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_decode.sv | 36 +++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun,
      StLuStall,
      StMemWait,
      StErr
   } hz_state_e;

   // RV32I major opcodes that affect source-register usage
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Instruction field positions
   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_W   = 7;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

endpackage

// File: rtl/hazard_decode.sv
// Extracts source registers from the ID instruction and decides which are really read.
module hazard_decode
   import hazard_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic [XLEN-1:0]   id_instr,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic              use_rs1,
   output logic              use_rs2
);

   logic [OPC_W-1:0] opcode;
   logic             unused_bits;

   assign opcode = id_instr[OPC_LSB +: OPC_W];
   assign rs1    = id_instr[RS1_LSB +: REG_AW];
   assign rs2    = id_instr[RS2_LSB +: REG_AW];

   // rd, funct3 and upper immediate bits never matter for hazards
   assign unused_bits = ^{id_instr[XLEN-1:RS2_LSB+REG_AW], id_instr[RS1_LSB-1:OPC_W]};

   // Operand usage by opcode class: U-type and JAL have no rs1, only R/S/B read rs2
   always_comb begin
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL:   use_rs1 = 1'b0;
         OPC_OP, OPC_STORE, OPC_BRANCH: use_rs2 = 1'b1;
         default:                       ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory freeze and
// memory-timeout watchdog. Define HAZARD_PERF_EN to add the saturating stall_cnt port.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   id_instr,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_valid,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_we,
   output logic              idex_bubble,
   output logic              exmem_we,
   output logic              mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   localparam int unsigned BC_W = $clog2(LOAD_LAT + 1);
   localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_e         state_q, ret_q, eff_st;
   logic [BC_W-1:0]   bc_q;
   logic [WC_W-1:0]   wc_q, wc_inc;
   logic [REG_AW-1:0] rs1, rs2;
   logic              use_rs1, use_rs2;
   logic              lu, frz;

   hazard_decode #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_decode (
      .id_instr (id_instr),
      .rs1      (rs1),
      .rs2      (rs2),
      .use_rs1  (use_rs1),
      .use_rs2  (use_rs2)
   );

   assign lu = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
               ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
   assign frz    = mem_req & ~mem_ready;
   // Once memory answers, the pipeline behaves as in the state it was frozen in
   assign eff_st = (state_q == StMemWait) ? ret_q : state_q;
   assign wc_inc = wc_q + WC_W'(1);

   // Output priority: reset, error, freeze, load-use stall, branch flush, new load-use
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_bubble = 1'b0;
      exmem_we    = 1'b1;
      mem_err     = 1'b0;
      if (!rst_n) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
      end else if (state_q == StErr) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         mem_err  = 1'b1;
      end else if (frz) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
      end else if (eff_st == StLuStall) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         // ID holds a wrong-path instruction, so any load-use match is moot
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // State, bubble counter and memory-wait watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         ret_q   <= StRun;
         bc_q    <= '0;
         wc_q    <= '0;
      end else if (state_q == StErr) begin
         state_q <= StErr;
      end else if (frz) begin
         if (state_q != StMemWait) begin
            ret_q <= state_q;
         end
         wc_q    <= wc_inc;
         state_q <= (wc_inc == WC_W'(MEM_TIMEOUT)) ? StErr : StMemWait;
      end else begin
         wc_q <= '0;
         if (eff_st == StLuStall) begin
            bc_q    <= bc_q - BC_W'(1);
            state_q <= (bc_q == BC_W'(1)) ? StRun : StLuStall;
         end else if (!ex_branch_taken && lu) begin
            bc_q    <= BC_W'(LOAD_LAT - 1);
            state_q <= (LOAD_LAT > 1) ? StLuStall : StRun;
         end else begin
            state_q <= StRun;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Count cycles in which the PC is held, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!pc_we && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end
`else
   logic [STALL_CNT_W-1:0] unused_stall_cnt;
   assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT 1..3, MEM_TIMEOUT 4) share
// stimulus; a cycle-level model checks every cycle, plus hand-computed window totals.
module tb_hazard_ctrl;

   localparam int NI = 3;
   localparam int TO = 4;
   localparam int CW = 4;
   // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_err}
   localparam logic [6:0] OUT_IDLE   = 7'b1101010;
   localparam logic [6:0] OUT_BRANCH = 7'b1111110;

   localparam logic [31:0] I_ADD  = 32'h00A50533; // add x10,x10,x10
   localparam logic [31:0] I_ADDI = 32'h00A28093; // addi x1,x5,10
   localparam logic [31:0] I_LUI  = 32'h00050537; // lui with rs1 field = 10
   localparam logic [31:0] I_SW   = 32'h00A12023; // sw x10,0(x2)

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [4:0]  ex_rd;
   logic        ex_mem_read, ex_valid, ex_branch_taken, mem_req, mem_ready;

   logic [NI-1:0][6:0] obs;
`ifdef HAZARD_PERF_EN
   logic [NI-1:0][CW-1:0] cnt_obs;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   int m_owed[NI], m_frz[NI], m_cnt[NI];
   bit m_err[NI];
   int t_pc0[NI], t_bub[NI], t_fl[NI], t_err[NI];
   int s_pc0[NI], s_bub[NI], s_fl[NI], s_err[NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_err;
      hazard_ctrl #(
         .XLEN        (32),
         .REG_AW      (5),
         .LOAD_LAT    (g + 1),
         .MEM_TIMEOUT (TO),
         .STALL_CNT_W (CW)
      ) u_dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .id_instr        (id_instr),
         .id_valid        (id_valid),
         .ex_rd           (ex_rd),
         .ex_mem_read     (ex_mem_read),
         .ex_valid        (ex_valid),
         .ex_branch_taken (ex_branch_taken),
         .mem_req         (mem_req),
         .mem_ready       (mem_ready),
         .pc_we           (pc_we),
         .ifid_we         (ifid_we),
         .ifid_flush      (ifid_flush),
         .idex_we         (idex_we),
         .idex_bubble     (idex_bubble),
         .exmem_we        (exmem_we),
         .mem_err         (mem_err)
`ifdef HAZARD_PERF_EN
         ,
         .stall_cnt       (cnt_obs[g])
`endif
      );
      assign obs[g] = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, mem_err};
   end

   // Load-use condition straight from the operand-usage rules
   function automatic bit spec_lu();
      logic [6:0] opc;
      bit u1, u2;
      opc = id_instr[6:0];
      u1  = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
      u2  = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
      return ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
             ((u1 && (id_instr[19:15] == ex_rd)) || (u2 && (id_instr[24:20] == ex_rd)));
   endfunction

   // Model: owed = stall cycles still due, frz = consecutive frozen cycles
   task automatic compare_cycle();
      bit lu, frz;
      lu  = spec_lu();
      frz = mem_req && !mem_ready;
      for (int i = 0; i < NI; i++) begin
         logic [6:0] exp;
         bit pc, ifd, fl, idx, bub, exm, er;
         pc = 1; ifd = 1; fl = 0; idx = 1; bub = 0; exm = 1; er = 0;
         if (!rst_n) begin
            pc = 0; ifd = 0; idx = 0; exm = 0;
            m_owed[i] = 0; m_frz[i] = 0; m_err[i] = 0;
         end else if (m_err[i]) begin
            pc = 0; ifd = 0; idx = 0; exm = 0; er = 1;
         end else if (frz) begin
            pc = 0; ifd = 0; idx = 0; exm = 0;
            m_frz[i]++;
            if (m_frz[i] >= TO) m_err[i] = 1;
         end else begin
            m_frz[i] = 0;
            if (m_owed[i] > 0) begin
               pc = 0; ifd = 0; bub = 1;
               m_owed[i]--;
            end else if (ex_branch_taken) begin
               fl = 1; bub = 1;
            end else if (lu) begin
               pc = 0; ifd = 0; bub = 1;
               m_owed[i] = i; // LOAD_LAT - 1
            end
         end
         exp = {pc, ifd, fl, idx, bub, exm, er};
         n_chk++;
         if (obs[i] !== exp) begin
            n_bad++;
            $display("FAIL outs inst%0d cyc%0d: got %b want %b", i, cyc, obs[i], exp);
         end
`ifdef HAZARD_PERF_EN
         n_chk++;
         if (cnt_obs[i] !== CW'(m_cnt[i])) begin
            n_bad++;
            $display("FAIL stall_cnt inst%0d cyc%0d: got %0d want %0d", i, cyc, cnt_obs[i],
                     m_cnt[i]);
         end
         if (!rst_n) m_cnt[i] = 0;
         else if (!pc && (m_cnt[i] < (1 << CW) - 1)) m_cnt[i]++;
`endif
         if (rst_n) begin
            t_pc0[i] += int'(!obs[i][6]);
            t_fl[i]  += int'(obs[i][4]);
            t_bub[i] += int'(obs[i][2]);
            t_err[i] += int'(obs[i][0]);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         compare_cycle();
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_lit(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic win_begin();
      for (int i = 0; i < NI; i++) begin
         s_pc0[i] = t_pc0[i]; s_bub[i] = t_bub[i]; s_fl[i] = t_fl[i]; s_err[i] = t_err[i];
      end
   endtask

   task automatic idle();
      id_instr = 32'h00000013; id_valid = 0; ex_rd = '0; ex_mem_read = 0; ex_valid = 0;
      ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic hazard(input logic [31:0] instr, input logic [4:0] rd, input bit idv);
      idle();
      id_instr = instr; id_valid = idv; ex_rd = rd; ex_mem_read = 1; ex_valid = 1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rd;
      bit          idv;
      int          stall;
   } vec_t;

   vec_t tbl[7] = '{
      '{I_ADD, 5'd10, 1'b1, 1}, '{I_ADD, 5'd0, 1'b1, 0}, '{I_ADDI, 5'd10, 1'b1, 0},
      '{I_ADDI, 5'd5, 1'b1, 1}, '{I_LUI, 5'd10, 1'b1, 0}, '{I_SW, 5'd10, 1'b1, 1},
      '{I_ADD, 5'd10, 1'b0, 0}
   };

   initial begin
      idle();
      rst_n = 0;
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("reset_outs_i%0d", i), obs[i], 0);
      step(3);
      rst_n = 1;
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("idle_outs_i%0d", i), obs[i], OUT_IDLE);
      step(2);

      // Operand-usage vectors: stall length scales with LOAD_LAT
      for (int k = 0; k < 7; k++) begin
         win_begin();
         hazard(tbl[k].instr, tbl[k].rd, tbl[k].idv);
         step(1);
         idle();
         step(4);
         for (int i = 0; i < NI; i++) begin
            check_lit($sformatf("lu_vec%0d_pc0_i%0d", k, i), t_pc0[i] - s_pc0[i],
                      tbl[k].stall * (i + 1));
            check_lit($sformatf("lu_vec%0d_bub_i%0d", k, i), t_bub[i] - s_bub[i],
                      tbl[k].stall * (i + 1));
         end
      end

      // Two-cycle freeze injected one cycle into the stall
      win_begin();
      hazard(I_ADD, 5'd10, 1);
      step(1);
      idle();
      step(1);
      mem_req = 1; mem_ready = 0;
      step(2);
      idle();
      step(5);
      for (int i = 0; i < NI; i++) begin
         check_lit($sformatf("frz_mid_pc0_i%0d", i), t_pc0[i] - s_pc0[i], i + 3);
         check_lit($sformatf("frz_mid_bub_i%0d", i), t_bub[i] - s_bub[i], i + 1);
      end

      // Freeze and load-use together: freeze first, hazard taken once memory answers
      win_begin();
      hazard(I_ADD, 5'd10, 1);
      mem_req = 1; mem_ready = 0;
      step(1);
      mem_ready = 1;
      step(1);
      idle();
      step(4);
      for (int i = 0; i < NI; i++) begin
         check_lit($sformatf("frz_lu_pc0_i%0d", i), t_pc0[i] - s_pc0[i], i + 2);
         check_lit($sformatf("frz_lu_bub_i%0d", i), t_bub[i] - s_bub[i], i + 1);
      end

      // Taken branch overrides load-use
      win_begin();
      hazard(I_ADD, 5'd10, 1);
      ex_branch_taken = 1;
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("br_outs_i%0d", i), obs[i], OUT_BRANCH);
      step(1);
      idle();
      step(4);
      for (int i = 0; i < NI; i++) begin
         check_lit($sformatf("br_pc0_i%0d", i), t_pc0[i] - s_pc0[i], 0);
         check_lit($sformatf("br_flush_i%0d", i), t_fl[i] - s_fl[i], 1);
      end

      // Memory timeout: 4 frozen cycles, then sticky error
      win_begin();
      idle();
      mem_req = 1; mem_ready = 0;
      step(4);
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("to_err_i%0d", i), obs[i][0], 1);
      step(2);
      idle();
      step(3);
      for (int i = 0; i < NI; i++) begin
         check_lit($sformatf("to_errcnt_i%0d", i), t_err[i] - s_err[i], 5);
         check_lit($sformatf("to_pc0_i%0d", i), t_pc0[i] - s_pc0[i], 9);
      end
      rst_n = 0;
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("to_rst_i%0d", i), obs[i], 0);
      step(1);
      rst_n = 1;
      #1;
      for (int i = 0; i < NI; i++) check_lit($sformatf("to_clear_i%0d", i), obs[i], OUT_IDLE);
      step(2);

      // Memory answers on the third cycle: no error
      win_begin();
      mem_req = 1; mem_ready = 0;
      step(2);
      mem_ready = 1;
      step(1);
      idle();
      step(3);
      for (int i = 0; i < NI; i++) begin
         check_lit($sformatf("rdy3_err_i%0d", i), t_err[i] - s_err[i], 0);
         check_lit($sformatf("rdy3_pc0_i%0d", i), t_pc0[i] - s_pc0[i], 2);
      end

      // Reset in mid-stall aborts the stall
      hazard(I_ADD, 5'd10, 1);
      step(1);
      idle();
      rst_n = 0;
      step(1);
      rst_n = 1;
      win_begin();
      step(3);
      for (int i = 0; i < NI; i++)
         check_lit($sformatf("rst_abort_pc0_i%0d", i), t_pc0[i] - s_pc0[i], 0);

`ifdef HAZARD_PERF_EN
      rst_n = 0;
      step(1);
      rst_n = 1;
      repeat (2) begin
         hazard(I_ADD, 5'd10, 1);
         step(1);
         idle();
         step(3);
      end
      for (int i = 0; i < NI; i++)
         check_lit($sformatf("perf_two_i%0d", i), cnt_obs[i], 2 * (i + 1));
      repeat (6) begin
         hazard(I_ADD, 5'd10, 1);
         step(1);
         idle();
         step(3);
      end
      check_lit("perf_sat_i0", cnt_obs[0], 8);
      check_lit("perf_sat_i1", cnt_obs[1], 15);
      check_lit("perf_sat_i2", cnt_obs[2], 15);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
